// File: rtl/por_reset_seq_pkg.sv
// Shared constants and helpers for the power-on / reset-release sequencer.
// Hold times assume a 50 MHz clk.
package por_pkg;

    localparam int POR_HOLD_20MS  = 1000000;
    localparam int POR_HOLD_100MS = 5000000;
    localparam int POR_SEQ_GAP    = 1000;

    // Channel 0 waits the long power-up hold; later channels only wait the gap.
    function automatic int por_thr(input int idx, input int hold, input int gap);
        return (idx == 0) ? hold : gap;
    endfunction

endpackage

// File: rtl/por_reset_seq_if.sv
// Request / status bundle between the board-level reset pins and the sequencer.
// The master drives requests and clears; the slave (the sequencer) reports status.
interface por_reset_seq_if #(
    parameter int CH = 3
);
    logic [CH-1:0] in;
    logic          clr_lost;
    logic [CH-1:0] out;
    logic          all_ok;
    logic [CH-1:0] lost;

    modport master (
        output in,
        output clr_lost,
        input  out,
        input  all_ok,
        input  lost
    );

    modport slave (
        input  in,
        input  clr_lost,
        output out,
        output all_ok,
        output lost
    );
endinterface

// File: rtl/por_reset_seq_chan.sv
// One release channel: saturating quiet-time counter, release register and
// sticky lost flag. Inputs are already synchronised.
module por_chan
    import por_pkg::*;
#(
    parameter int CNT_W         = 24,
    parameter int THR           = POR_SEQ_GAP,
    parameter bit INIT_RELEASED = 1'b0
) (
    input  logic clk,
    input  logic rst_l,
    input  logic req_i,
    input  logic in_s_i,
    input  logic clr_lost_i,
    output logic out_o,
    output logic lost_o
);

    localparam logic [CNT_W-1:0] THR_C = CNT_W'(THR);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             lost_q, lost_d;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (req_i) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else begin
            if (cnt_q < THR_C) begin
                cnt_d = cnt_q + 1'b1;
            end
            out_d = (cnt_q >= THR_C);
        end
    end

    // A drop caused by this channel's own request is sticky; set beats clear.
    always_comb begin
        lost_d = lost_q;
        if (out_q && in_s_i) begin
            lost_d = 1'b1;
        end else if (clr_lost_i) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q  <= INIT_RELEASED ? THR_C : '0;
            out_q  <= INIT_RELEASED;
            lost_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            lost_q <= lost_d;
        end
    end

    assign out_o  = out_q;
    assign lost_o = lost_q;

endmodule

// File: rtl/por_reset_seq.sv
// Multi-channel reset-release sequencer: synchronises reset requests and
// releases channels in order 0..CH-1 after their quiet times.
module por_reset_seq
    import por_pkg::*;
#(
    parameter int CH            = 3,
    parameter int CNT_W         = 24,
    parameter int HOLD_CYC      = POR_HOLD_100MS,
    parameter int SEQ_GAP       = POR_SEQ_GAP,
    parameter bit INIT_RELEASED = 1'b0
) (
    input  logic            clk,
    input  logic            rst_l,
    por_reset_seq_if.slave  bus_if
);

    // Synchronisers reset to "request active" unless channels start released.
    localparam logic [CH-1:0] SYNC_RST = INIT_RELEASED ? {CH{1'b0}} : {CH{1'b1}};

    logic [CH-1:0] sync1_q;
    logic [CH-1:0] in_s_q;
    logic [CH-1:0] req;
    logic [CH-1:0] out_w;
    logic [CH-1:0] lost_w;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync1_q <= SYNC_RST;
            in_s_q  <= SYNC_RST;
        end else begin
            sync1_q <= bus_if.in;
            in_s_q  <= sync1_q;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        if (i == 0) begin : g_first
            assign req[i] = in_s_q[i];
        end else begin : g_next
            // Cascade: a channel is held while its predecessor is not released.
            assign req[i] = in_s_q[i] | ~out_w[i-1];
        end

        por_chan #(
            .CNT_W         (CNT_W),
            .THR           (por_thr(i, HOLD_CYC, SEQ_GAP)),
            .INIT_RELEASED (INIT_RELEASED)
        ) u_chan (
            .clk        (clk),
            .rst_l      (rst_l),
            .req_i      (req[i]),
            .in_s_i     (in_s_q[i]),
            .clr_lost_i (bus_if.clr_lost),
            .out_o      (out_w[i]),
            .lost_o     (lost_w[i])
        );
    end

    assign bus_if.out    = out_w;
    assign bus_if.all_ok = &out_w;
    assign bus_if.lost   = lost_w;

endmodule

// File: tb/tb_por_reset_seq.sv
// Directed bench for por_reset_seq with CH=3, HOLD_CYC=10, SEQ_GAP=4; a second
// instance covers the start-released configuration.
module tb_por_reset_seq;

    logic clk = 1'b0;
    logic rst_l;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n;

    always #5 clk = ~clk;

    por_reset_seq_if #(.CH(3)) bus0 ();
    por_reset_seq_if #(.CH(3)) bus1 ();

    por_reset_seq #(
        .CH(3), .CNT_W(8), .HOLD_CYC(10), .SEQ_GAP(4), .INIT_RELEASED(1'b0)
    ) dut0 (
        .clk    (clk),
        .rst_l  (rst_l),
        .bus_if (bus0.slave)
    );

    por_reset_seq #(
        .CH(3), .CNT_W(8), .HOLD_CYC(10), .SEQ_GAP(4), .INIT_RELEASED(1'b1)
    ) dut1 (
        .clk    (clk),
        .rst_l  (rst_l),
        .bus_if (bus1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until out[idx] is high, bounded so a stuck output still ends the run.
    task automatic wait_bit(input int idx, output int edges);
        edges = 0;
        do begin
            tick(1);
            edges++;
        end while (bus0.out[idx] !== 1'b1 && edges < 60);
    endtask

    logic [2:0] rip_exp [5];
    logic [2:0] mid_exp [5];

    initial begin
        rip_exp = '{3'b111, 3'b111, 3'b110, 3'b100, 3'b000};
        mid_exp = '{3'b111, 3'b111, 3'b101, 3'b001, 3'b001};

        rst_l         = 1'b0;
        bus0.in       = '0;
        bus0.clr_lost = 1'b0;
        bus1.in       = '0;
        bus1.clr_lost = 1'b0;

        // reset state
        tick(3);
        chk("rst_out",     32'(bus0.out), 32'h0);
        chk("rst_all_ok",  32'(bus0.all_ok), 32'h0);
        chk("rst_lost",    32'(bus0.lost), 32'h0);
        chk("rst_out_ir",  32'(bus1.out), 32'h7);
        chk("rst_ok_ir",   32'(bus1.all_ok), 32'h1);

        // power-up sequence
        rst_l = 1'b1;
        wait_bit(0, n); chk("pwr_out0", n, 13);
        wait_bit(1, n); chk("pwr_out1", n, 5);
        wait_bit(2, n); chk("pwr_out2", n, 5);
        chk("pwr_all_ok", 32'(bus0.all_ok), 32'h1);
        chk("pwr_lost",   32'(bus0.lost), 32'h0);
        chk("pwr_out_ir", 32'(bus1.out), 32'h7);

        // assert ripple from channel 0
        bus0.in[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (k == 2) bus0.in[0] = 1'b0;
            chk($sformatf("rip_out_%0d", k), 32'(bus0.out), 32'(rip_exp[k]));
        end
        chk("rip_lost",   32'(bus0.lost), 32'h1);
        chk("rip_all_ok", 32'(bus0.all_ok), 32'h0);
        wait_bit(0, n); chk("rip_rel0", n, 11);
        wait_bit(1, n); chk("rip_rel1", n, 5);
        wait_bit(2, n); chk("rip_rel2", n, 5);

        // glitch during counting restarts the quiet time
        bus0.in[0] = 1'b1;
        tick(1);
        bus0.in[0] = 1'b0;
        tick(1);
        chk("rst_glitch_r1", 32'(bus0.out), 32'h7);
        tick(1);
        chk("rst_glitch_r2", 32'(bus0.out), 32'h6);
        tick(5);
        bus0.in[0] = 1'b1;
        tick(1);
        bus0.in[0] = 1'b0;
        wait_bit(0, n); chk("restart_rel0", n, 13);
        wait_bit(1, n); chk("restart_rel1", n, 5);
        wait_bit(2, n); chk("restart_rel2", n, 5);
        chk("restart_lost", 32'(bus0.lost), 32'h1);

        bus0.clr_lost = 1'b1;
        tick(1);
        bus0.clr_lost = 1'b0;
        chk("clr_lost0", 32'(bus0.lost), 32'h0);

        // middle channel request
        bus0.in[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (k == 4) bus0.in[1] = 1'b0;
            chk($sformatf("mid_out_%0d", k), 32'(bus0.out), 32'(mid_exp[k]));
        end
        chk("mid_lost", 32'(bus0.lost), 32'h2);
        wait_bit(1, n); chk("mid_rel1", n, 7);
        wait_bit(2, n); chk("mid_rel2", n, 5);

        // set and clear on the same edge: set wins
        bus0.in[1] = 1'b1;
        tick(2);
        bus0.in[1]    = 1'b0;
        bus0.clr_lost = 1'b1;
        tick(1);
        bus0.clr_lost = 1'b0;
        chk("sticky_lost", 32'(bus0.lost), 32'h2);
        chk("sticky_out",  32'(bus0.out), 32'h5);
        bus0.clr_lost = 1'b1;
        tick(1);
        bus0.clr_lost = 1'b0;
        chk("lone_clr", 32'(bus0.lost), 32'h0);
        wait_bit(2, n); chk("sticky_rel2", n, 10);
        chk("sticky_all_ok", 32'(bus0.all_ok), 32'h1);

        // reset while channel 0 is mid-count
        bus0.in[0] = 1'b1;
        tick(1);
        bus0.in[0] = 1'b0;
        tick(8);
        chk("mc_lost_pre", 32'(bus0.lost), 32'h1);
        rst_l = 1'b0;
        #1;
        chk("mc_out",    32'(bus0.out), 32'h0);
        chk("mc_lost",   32'(bus0.lost), 32'h0);
        chk("mc_out_ir", 32'(bus1.out), 32'h7);
        chk("mc_ok_ir",  32'(bus1.all_ok), 32'h1);
        tick(2);
        rst_l = 1'b1;
        wait_bit(0, n); chk("mc_rel0", n, 13);
        wait_bit(1, n); chk("mc_rel1", n, 5);
        wait_bit(2, n); chk("mc_rel2", n, 5);

        // asynchronous reset from the fully released state
        #3;
        rst_l = 1'b0;
        #1;
        chk("async_out",    32'(bus0.out), 32'h0);
        chk("async_all_ok", 32'(bus0.all_ok), 32'h0);
        chk("async_out_ir", 32'(bus1.out), 32'h7);
        tick(2);
        rst_l = 1'b1;
        tick(3);
        chk("post_out_ir",  32'(bus1.out), 32'h7);
        chk("post_ok_ir",   32'(bus1.all_ok), 32'h1);
        chk("post_lost_ir", 32'(bus1.lost), 32'h0);
        chk("post_out",     32'(bus0.out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/por_reset_seq.md
# por_reset_seq

Multi-channel power-on / reset-release sequencer, the parametrised successor of the single-channel POR hold-off counter. Each of `CH` channels synchronises an asynchronous reset-request input, holds its output low while the request is active, and releases only after a programmable quiet time. Releases follow a fixed order (channel 0 first), with an inter-channel gap. Sits at the top of the CPLD, fed by power-good/reset pins, and drives the reset of the I2C logic and external devices.

## Interface
- `CH`, 3: channel count, ≥1.
- `CNT_W`, 24: counter width; must hold max(`HOLD_CYC`, `SEQ_GAP`).
- `HOLD_CYC`, 5000000: quiet cycles before channel 0 releases (100 ms at 50 MHz); ≥1.
- `SEQ_GAP`, 1000: quiet cycles before channel i>0 releases, counted after `out[i-1]` rises; ≥1.
- `INIT_RELEASED`, 0: 1 means all channels come out of reset already released.

Ports:
- `clk`  in  1: clock.
- `rst_l`  in  1: reset, asynchronous, active-low.
- `in`  in  CH: reset request per channel, active-high, asynchronous.
- `clr_lost`  in  1: synchronous pulse, clears `lost`.
- `out`  out  CH: channel released (1) / held in reset (0).
- `all_ok`  out  1: AND of all `out` bits.
- `lost`  out  CH: sticky flag; channel dropped because of its own request.

## Operation
- Synchroniser: 2-FF per `in` bit, giving `in_s`.
- Effective request: `req[0] = in_s[0]`; `req[i] = in_s[i] | ~out[i-1]`.
- Threshold: `THR[0] = HOLD_CYC`; `THR[i] = SEQ_GAP`.
- Per channel, on each edge:
  - `req` = 1: `cnt <= 0`, `out <= 0`.
  - Otherwise: `cnt` increments while `cnt < THR`. It saturates at `THR` and never wraps.
  - `out <= (cnt >= THR)`.
- `lost[i]` is set on the edge where `out[i]` goes 1→0 while `in_s[i]` = 1. Cascade-only drops do not set it. It is cleared by `clr_lost`; if set and clear occur together, set wins.
- Reset values:
  - `INIT_RELEASED`=0: `cnt` = 0, `out` = 0, `all_ok` = 0, `lost` = 0, sync FFs = 1 (request active).
  - `INIT_RELEASED`=1: `cnt` = `THR`, `out` = all 1, `all_ok` = 1, `lost` = 0, sync FFs = 0.
- Reset mid-operation: all state returns to reset values immediately. Any partial count is discarded.
- `all_ok` is combinational from registered `out`.

## Timing
- Assert latency: raw `in[j]` first sampled high at edge R gives `out[j]` = 0 after edge R+2. `out[k]` for k>j drops one edge later per channel: `out[j+m]` = 0 after R+2+m.
- Release latency: let E be the first edge where `req[0]` is sampled 0.
  - `out[0]` rises at edge E+`HOLD_CYC`.
  - `out[i]` rises at E+`HOLD_CYC`+i·(`SEQ_GAP`+1).
- Request pulse during counting, even 1 cycle after sync: the counter restarts from 0 and the full quiet time applies again.
- Request on channel i>0 only: channels <i are unaffected. Channel i and higher release in sequence once the request clears.
- Pulses shorter than one `clk` may be missed. This is accepted; no filtering beyond the sync FFs.

## Structure
- Shared package `por_pkg`: constants `POR_HOLD_20MS` = 1000000 and `POR_HOLD_100MS` = 5000000 (50 MHz), plus the default `SEQ_GAP`.
- Sub-module `por_chan`: sync-free counter, `out` register and `lost` flag, with `THR` as a parameter. The top instantiates it `CH` times with a generate loop and holds the synchronisers and the cascade wiring.

## Test plan
All scenarios use `CH`=3, `HOLD_CYC`=10, `SEQ_GAP`=4, `INIT_RELEASED`=0.
- Power-up: `rst_l` released, `in` = 0 → `out` = 000 during reset; `out[0]` high 12 edges after the first post-reset edge; `out[1]` 5 edges later; `out[2]` 5 edges after that; then `all_ok` = 1 and `lost` = 000.
- Assert ripple: all released, pulse `in[0]` for 3 cycles → `out[0]` low at R+2, `out[1]` at R+3, `out[2]` at R+4. `lost` = 001. Re-release follows the same spacing as power-up.
- Restart: `in[0]` glitch 1 cycle when `cnt[0]` = 7 → `cnt[0]` returns to 0. `out[0]` rises 10 edges after the glitch clears in `in_s`, not 3.
- Middle channel: all released, `in[1]` held 5 cycles → `out[0]` stays 1; `out[1]` and `out[2]` drop. `lost` = 010. `out[1]` rises 4 edges after `req[1]` clears.
- Sticky clear: `lost` = 010, then `clr_lost` coincident with a new `in[1]` drop → `lost[1]` stays 1. A later lone `clr_lost` → `lost` = 000.
- Reset mid-count: `rst_l` low with `cnt[0]` = 6 → `out` = 000 and `cnt` = 0 asynchronously. Repeat with `INIT_RELEASED`=1 → `out` = 111 and `all_ok` = 1 during and after reset.
